// File: rtl/draw_char_sprite.sv
// Character sprite overlay: ROM address generation plus keyed compositing.
// Define DRAW_CHAR_MIRROR_EN to enable horizontal mirroring via the mirror port.
module draw_char_sprite #(
  parameter int          IMG_W     = 128,
  parameter int          IMG_H     = 128,
  parameter logic [11:0] KEY_COLOR = 12'hF0F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  input  logic        mirror,
  output logic [13:0] rom_addr,
  input  logic [11:0] rom_rgb,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);

  typedef struct packed {
    logic [10:0] hc;
    logic [10:0] vc;
    logic        hs;
    logic        vs;
    logic        hb;
    logic        vb;
    logic [11:0] rgb;
    logic        hit;
  } pix_t;

  logic        vs_prev_q;
  logic [11:0] xpos_l_q;
  logic [11:0] ypos_l_q;
  logic [13:0] rom_addr_q;
  logic [13:0] rom_addr_d;
  pix_t        d1_q;
  pix_t        d1_d;
  pix_t        d2_q;
  pix_t        out_q;
  logic [11:0] rgb_d;

  logic [12:0] hc13;
  logic [12:0] vc13;
  logic [12:0] xl13;
  logic [12:0] yl13;
  logic [12:0] dx;
  logic [12:0] dy;
  logic        hit;
  logic [6:0]  xm;
  logic        vs_rise;

  assign hc13    = {2'b00, hcount_in};
  assign vc13    = {2'b00, vcount_in};
  assign xl13    = {1'b0, xpos_l_q};
  assign yl13    = {1'b0, ypos_l_q};
  assign dx      = hc13 - xl13;
  assign dy      = vc13 - yl13;
  assign vs_rise = vsync_in & ~vs_prev_q;

  // 13-bit bounds so a sprite near the 12-bit limit never wraps to 0
  assign hit = (hc13 >= xl13) && (hc13 < xl13 + 13'(IMG_W)) &&
               (vc13 >= yl13) && (vc13 < yl13 + 13'(IMG_H));

`ifdef DRAW_CHAR_MIRROR_EN
  logic mir_l_q;
  logic unused_bits;

  assign xm          = mir_l_q ? 7'(IMG_W - 1) - dx[6:0] : dx[6:0];
  assign unused_bits = ^{dx[12:7], dy[12:7]};

  always_ff @(posedge clk) begin
    if (rst) begin
      mir_l_q <= 1'b0;
    end else if (vs_rise) begin
      mir_l_q <= mirror;
    end
  end
`else
  logic unused_bits;

  assign xm          = dx[6:0];
  assign unused_bits = ^{mirror, dx[12:7], dy[12:7]};
`endif

  always_comb begin
    rom_addr_d = hit ? {dy[6:0], xm} : 14'd0;
    d1_d.hc    = hcount_in;
    d1_d.vc    = vcount_in;
    d1_d.hs    = hsync_in;
    d1_d.vs    = vsync_in;
    d1_d.hb    = hblnk_in;
    d1_d.vb    = vblnk_in;
    d1_d.rgb   = rgb_in;
    d1_d.hit   = hit;
  end

  always_comb begin
    rgb_d = d2_q.rgb;
    if (d2_q.hb | d2_q.vb) begin
      rgb_d = 12'h000;
    end else if (d2_q.hit && (rom_rgb != KEY_COLOR)) begin
      rgb_d = rom_rgb;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_prev_q  <= 1'b0;
      xpos_l_q   <= 12'd0;
      ypos_l_q   <= 12'd0;
      rom_addr_q <= 14'd0;
      d1_q       <= '0;
      d2_q       <= '0;
      out_q      <= '0;
    end else begin
      vs_prev_q  <= vsync_in;
      if (vs_rise) begin
        xpos_l_q <= xpos;
        ypos_l_q <= ypos;
      end
      rom_addr_q <= rom_addr_d;
      d1_q       <= d1_d;
      d2_q       <= d1_q;
      out_q      <= d2_q;
      out_q.rgb  <= rgb_d;
    end
  end

  assign rom_addr   = rom_addr_q;
  assign hcount_out = out_q.hc;
  assign vcount_out = out_q.vc;
  assign hsync_out  = out_q.hs;
  assign vsync_out  = out_q.vs;
  assign hblnk_out  = out_q.hb;
  assign vblnk_out  = out_q.vb;
  assign rgb_out    = out_q.rgb;

endmodule

// File: tb/tb_draw_char_sprite.sv
// Scoreboard bench for draw_char_sprite with a behavioural 1-cycle ROM.
// Honours DRAW_CHAR_MIRROR_EN in its reference model.
module tb_draw_char_sprite;

  localparam logic [11:0] KEY = 12'hF0F;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] hcount_in = '0;
  logic [10:0] vcount_in = '0;
  logic        hsync_in = 1'b0;
  logic        vsync_in = 1'b0;
  logic        hblnk_in = 1'b0;
  logic        vblnk_in = 1'b0;
  logic [11:0] rgb_in = '0;
  logic [11:0] xpos = '0;
  logic [11:0] ypos = '0;
  logic        mirror = 1'b0;
  logic [13:0] rom_addr;
  logic [11:0] rom_rgb = '0;
  logic [10:0] hcount_out;
  logic [10:0] vcount_out;
  logic        hsync_out;
  logic        vsync_out;
  logic        hblnk_out;
  logic        vblnk_out;
  logic [11:0] rgb_out;

  draw_char_sprite dut (
    .clk(clk), .rst(rst),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos),
    .mirror(mirror), .rom_addr(rom_addr), .rom_rgb(rom_rgb),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out),
    .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out)
  );

  always #5 clk = ~clk;

  logic [11:0] rom_mem [logic [13:0]];

  function automatic logic [11:0] rom_val(input logic [13:0] a);
    if (rom_mem.exists(a)) return rom_mem[a];
    return a[11:0] ^ 12'h5A5;
  endfunction

  always @(posedge clk) rom_rgb <= rom_val(rom_addr);

  typedef struct {
    logic [25:0] tim;
    logic [11:0] rgb;
  } exp_t;

  exp_t        oq[$];
  logic [13:0] aq[$];
  int ncmp = 0;
  int nerr = 0;

  int lx = 0;
  int ly = 0;
  bit lm = 0;
  bit pvs = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int hc, input int vc, input bit vs,
                      input bit hb, input bit vb, input logic [11:0] bg);
    exp_t e;
    int dxm;
    bit h;
    logic [13:0] a;
    logic [11:0] rv;
    @(negedge clk);
    if (aq.size() == 1) chk("rom_addr", 32'(rom_addr), 32'(aq.pop_front()));
    if (oq.size() == 3) begin
      e = oq.pop_front();
      chk("timing", 32'({hcount_out, vcount_out, hsync_out, vsync_out,
                         hblnk_out, vblnk_out}), 32'(e.tim));
      chk("rgb_out", 32'(rgb_out), 32'(e.rgb));
    end
    hcount_in = 11'(hc);
    vcount_in = 11'(vc);
    hsync_in  = (hc >= 1048 && hc < 1184);
    vsync_in  = vs;
    hblnk_in  = hb;
    vblnk_in  = vb;
    rgb_in    = bg;
    h = (hc >= lx) && (hc < lx + 128) && (vc >= ly) && (vc < ly + 128);
    dxm = (hc - lx) & 127;
`ifdef DRAW_CHAR_MIRROR_EN
    if (lm) dxm = 127 - dxm;
`endif
    a = h ? 14'(((vc - ly) & 127) * 128 + dxm) : 14'd0;
    rv = rom_val(a);
    e.tim = {11'(hc), 11'(vc), hsync_in, vs, hb, vb};
    if (hb || vb) e.rgb = 12'h000;
    else if (h && rv != KEY) e.rgb = rv;
    else e.rgb = bg;
    aq.push_back(a);
    oq.push_back(e);
    if (vs && !pvs) begin
      lx = int'(xpos);
      ly = int'(ypos);
      lm = mirror;
    end
    pvs = vs;
  endtask

  task automatic do_reset(input int n);
    oq.delete();
    aq.delete();
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      hcount_in = 11'($urandom);
      vcount_in = 11'($urandom);
      hsync_in  = 1'($urandom);
      vsync_in  = 1'($urandom);
      hblnk_in  = 1'($urandom);
      vblnk_in  = 1'($urandom);
      rgb_in    = 12'($urandom);
      @(negedge clk);
      chk("rst_addr", 32'(rom_addr), 32'd0);
      chk("rst_out", 32'({hcount_out, vcount_out, hsync_out, vsync_out,
                          hblnk_out, vblnk_out, rgb_out}), 32'd0);
    end
    rst = 1'b0;
    hcount_in = '0;
    vcount_in = '0;
    hsync_in  = 1'b0;
    vsync_in  = 1'b0;
    hblnk_in  = 1'b0;
    vblnk_in  = 1'b0;
    rgb_in    = '0;
    lx = 0;
    ly = 0;
    lm = 0;
    pvs = 0;
  endtask

  task automatic vpulse(input int nx, input int ny, input bit m);
    xpos = 12'(nx);
    ypos = 12'(ny);
    mirror = m;
    tick(0, 600, 1'b0, 1'b1, 1'b1, 12'h000);
    tick(0, 601, 1'b1, 1'b1, 1'b1, 12'h000);
    tick(0, 602, 1'b1, 1'b1, 1'b1, 12'h000);
    tick(0, 603, 1'b0, 1'b1, 1'b1, 12'h000);
  endtask

  initial begin
    rom_mem[14'h0505] = 12'h0A3;
    rom_mem[14'h0506] = KEY;
    do_reset(4);
    for (int i = 0; i < 4; i++) tick(500 + i, 300, 0, 0, 0, 12'h3C0 + 12'(i));
    // latched position starts at origin after reset
    tick(5, 5, 0, 0, 0, 12'h111);
    vpulse(100, 50, 0);
    tick(105, 60, 0, 0, 0, 12'h777);
    tick(106, 60, 0, 0, 0, 12'h123);
    tick(228, 60, 0, 0, 0, 12'h456);
    tick(227, 60, 0, 0, 0, 12'h456);
    tick(99, 60, 0, 0, 0, 12'h456);
    tick(100, 60, 0, 0, 0, 12'h456);
    tick(105, 49, 0, 0, 0, 12'h456);
    tick(105, 177, 0, 0, 0, 12'h456);
    tick(105, 178, 0, 0, 0, 12'h456);
    xpos = 12'd300;
    tick(105, 61, 0, 0, 0, 12'h222);
    tick(300, 61, 0, 0, 0, 12'h222);
    tick(105, 61, 0, 0, 0, 12'h222);
    tick(105, 61, 1, 0, 0, 12'h222);
    tick(105, 61, 1, 0, 0, 12'h222);
    tick(300, 61, 0, 0, 0, 12'h333);
    tick(427, 61, 0, 0, 0, 12'h333);
    tick(428, 61, 0, 0, 0, 12'h333);
    vpulse(100, 50, 1);
    tick(100, 60, 0, 0, 0, 12'h444);
    tick(227, 60, 0, 0, 0, 12'h444);
    tick(150, 100, 0, 0, 0, 12'h444);
    vpulse(4090, 50, 0);
    tick(0, 60, 0, 0, 0, 12'h555);
    tick(1023, 60, 0, 0, 0, 12'h555);
    tick(2047, 100, 0, 0, 0, 12'h555);
    tick(1, 60, 0, 0, 0, 12'h555);
    vpulse(100, 50, 0);
    tick(105, 60, 0, 1, 0, 12'h666);
    tick(110, 70, 0, 0, 1, 12'h666);
    tick(110, 70, 0, 0, 0, 12'h666);
    for (int i = 0; i < 60; i++) begin
      if (i % 20 == 0) begin
        xpos = 12'($urandom_range(0, 300));
        ypos = 12'($urandom_range(0, 200));
        mirror = 1'($urandom);
      end
      tick($urandom_range(0, 450), $urandom_range(0, 350),
           (i % 20 == 1), ($urandom_range(0, 7) == 0), 1'b0,
           12'($urandom));
    end
    // mid-frame reset must drop the latched position back to 0
    do_reset(2);
    tick(5, 5, 0, 0, 0, 12'h888);
    tick(130, 5, 0, 0, 0, 12'h888);
    for (int i = 0; i < 4; i++) tick(700, 400, 0, 1, 0, 12'h000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/draw_char_sprite.md
Name: draw_char_sprite

Overview:
- Consumer side of the character image ROM interface. Generates the 14-bit ROM read address from the VGA timing stream and overlays the returned 12-bit pixel onto the incoming background stream.
- Sits in the VGA pipeline between the background/platform drawer and the VGA output register stage.
- Handles the ROM's 1-cycle registered read latency by delaying all timing signals.
- Supports a transparency colour key and horizontal mirroring (character facing).

Parameters:
- IMG_W, 128, sprite width in pixels; must equal 2^7 (address x field is 7 bits).
- IMG_H, 128, sprite height in pixels; must equal 2^7 (address y field is 7 bits).
- KEY_COLOR, 12'hF0F, ROM pixel value treated as transparent.

Ports:
- clk  input  1  pixel clock.
- rst  input  1  synchronous active-high reset.
- hcount_in  input  11  horizontal pixel counter.
- vcount_in  input  11  vertical line counter.
- hsync_in  input  1  horizontal sync.
- vsync_in  input  1  vertical sync.
- hblnk_in  input  1  horizontal blanking.
- vblnk_in  input  1  vertical blanking.
- rgb_in  input  12  background pixel.
- xpos  input  12  sprite left edge, screen pixels, unsigned.
- ypos  input  12  sprite top edge, screen lines, unsigned.
- mirror  input  1  1 = draw horizontally flipped.
- rom_addr  output  14  ROM address, {y[6:0], x[6:0]}.
- rom_rgb  input  12  ROM data; valid one clk after rom_addr.
- hcount_out, vcount_out  output  11  timing delayed 3 clks.
- hsync_out, vsync_out, hblnk_out, vblnk_out  output  1  timing delayed 3 clks.
- rgb_out  output  12  composited pixel.

Behaviour:
- All state updates on the posedge of clk. rst is synchronous and active-high.
- Reset clears every output and internal register to 0, including the latched position and mirror flag.

Frame latch:
- xpos, ypos and mirror are captured into xpos_l, ypos_l and mir_l only on the vsync_in rising edge: vsync_in=1 and previous-cycle vsync_in=0.
- The latched values hold for the whole frame, so the sprite never tears mid-frame.
- After a reset, including a reset mid-frame, the latched values are 0 until the next rising edge.

Stage 1 (edge E1):
- dx = hcount_in - xpos_l and dy = vcount_in - ypos_l, both computed 13 bits wide.
- hit = (hcount_in >= xpos_l) and (hcount_in < xpos_l+IMG_W) and (vcount_in >= ypos_l) and (vcount_in < ypos_l+IMG_H). The sums are 13-bit, so there is no wrap when xpos is near 4095.
- Address x field: xm = mir_l ? (IMG_W-1-dx[6:0]) : dx[6:0].
- rom_addr <= hit ? {dy[6:0], xm} : 14'd0.
- hit, all timing inputs and rgb_in are registered into d1.

Stage 2 (edge E2):
- The ROM registers rom_rgb.
- The d1 values are copied into d2.

Stage 3 (edge E3), output registers:
- Timing outputs <= d2 timing.
- rgb_out <= 12'h000 if (hblnk_d2 | vblnk_d2); else rom_rgb if (hit_d2 and rom_rgb != KEY_COLOR); else rgb_d2.
- Total latency from inputs to outputs is exactly 3 clks for every signal.

Clipping:
- A sprite partially beyond the right or bottom of the visible area is cut off by blanking.
- A sprite fully off-screen (xpos >= 1024) produces no hit and passes the background through unchanged.
- Negative positions are not supported.

Simultaneous events:
- If the vsync rising edge and a hit occur in the same cycle, stage 1 uses the old latched values. The new values take effect the next cycle.

Optional Feature:
- Macro: DRAW_CHAR_MIRROR_EN.
- Defined: the mirror port is captured into mir_l and selects the flipped x field as described above.
- Undefined: the mirror port is ignored, mir_l is not implemented, and the x field is always dx[6:0]. All other behaviour is identical.

Test Plan:
- Reset: hold rst=1 for 4 clks while driving arbitrary timing -> all outputs 0 and rom_addr=0; after release, 3 clks later the outputs track the inputs delayed by 3.
- Basic hit: xpos=100, ypos=50 latched via a vsync pulse; at hcount=105, vcount=60 -> rom_addr=14'h0505 one clk later. Driving rom_rgb=12'h0A3 gives rgb_out=12'h0A3 two clks after that.
- Transparency and miss:
  - At the same hit with rom_rgb=KEY_COLOR and rgb_in=12'h123 -> rgb_out=12'h123.
  - At hcount=228, one pixel past the edge -> rom_addr=0 and rgb_out=rgb_in delayed.
- Frame latch: change xpos to 300 mid-frame -> the sprite stays at 100 until the next vsync rising edge, then the hit begins at hcount=300.
- Mirror (DRAW_CHAR_MIRROR_EN defined): mirror=1 latched, hcount=100 -> rom_addr x field=127; hcount=227 -> x field=0.
- Blanking/edge: xpos=4090 -> no hit anywhere and no wrap; during hblnk_in=1 -> rgb_out=0 regardless of hit.
